// File: rtl/ifetch_queue_pkg.sv
// Shared constants and payload layout for the instruction fetch queue.
package ifetch_queue_pkg;

    localparam logic [31:0] IFQ_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_4;
    } ifq_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO with clear; head is read combinationally from storage.
// Latency: push visible at head the cycle after; backpressure: push ignored when full, pop ignored when empty.
module ifq_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    input  logic                     clear,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];

    // Clear wins over both push and pop in the same cycle.
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !clear));

endmodule

// File: rtl/ifetch_queue.sv
// Fetch front end: owns the fetch PC, issues in-order imem requests, buffers {instr, pc+4} for decode.
// Latency: response visible to decode the cycle after it arrives; backpressure: credits stop requests when buffered+in-flight reaches DEPTH.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = IFQ_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc_4
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic          run_q, run_d;

    ifq_entry_t    buf_head, buf_push_dat;
    logic [CW-1:0] buf_count, tag_count;
    logic          buf_full, buf_empty, tag_full, tag_empty;
    logic [31:0]   tag_head, tag_push_dat;

    logic          req_fire, resp_take, resp_keep, buf_pop;
    logic [CW:0]   credit_used;
    logic          unused_tag_status;

    // Buffered entries plus every outstanding request (including ones to be dropped) consume a slot.
    assign credit_used    = {1'b0, buf_count} + {1'b0, inflight_q};
    assign imem_req_valid = run_q && (credit_used < DEPTH_W) && !redirect_valid;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign tag_push_dat   = fetch_pc_q + 32'd4;

    // A response with nothing outstanding belongs to a pre-reset request and is ignored.
    assign resp_take = imem_resp_valid && (inflight_q != '0);
    assign resp_keep = resp_take && (drop_q == '0) && !redirect_valid;
    assign buf_pop   = out_valid && out_ready && !redirect_valid;

    assign buf_push_dat = '{instr: imem_resp_data, pc_4: tag_head};

    assign out_valid = !buf_empty;
    assign out_instr = buf_empty ? NOP_INSTR : buf_head.instr;
    assign out_pc_4  = buf_empty ? 32'h0 : buf_head.pc_4;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        run_d      = 1'b1;
        inflight_d = inflight_q + CW'(req_fire) - CW'(resp_take);
        if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
        if (resp_take && (drop_q != '0)) drop_d = drop_q - CW'(1);
        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_pc);
            drop_d     = inflight_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            run_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            run_q      <= run_d;
        end
    end

    ifq_fifo #(.WIDTH($bits(ifq_entry_t)), .DEPTH(DEPTH)) u_buf_fifo (
        .clk      (clk),
        .rst_n    (rst),
        .push     (resp_keep),
        .push_dat (buf_push_dat),
        .pop      (buf_pop),
        .clear    (redirect_valid),
        .head_dat (buf_head),
        .full     (buf_full),
        .empty    (buf_empty),
        .count    (buf_count)
    );

    // Tag queue holds pc+4 for each live outstanding request, in issue order.
    ifq_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_fifo (
        .clk      (clk),
        .rst_n    (rst),
        .push     (req_fire),
        .push_dat (tag_push_dat),
        .pop      (resp_keep),
        .clear    (redirect_valid),
        .head_dat (tag_head),
        .full     (tag_full),
        .empty    (tag_empty),
        .count    (tag_count)
    );

    assign unused_tag_status = ^{tag_full, tag_empty, tag_count, buf_full};

    a_drop_bound: assert property (@(posedge clk) disable iff (!rst) drop_q <= inflight_q);
    a_tag_track:  assert property (@(posedge clk) disable iff (!rst) tag_count == (inflight_q - drop_q));

endmodule
